// File: rtl/apb_timer_multi_pkg.sv
// Shared types and register map for the multi-channel APB timer.
// CASCADE field is only functional when TIMER_CASCADE_EN is defined.
package apb_timer_multi_pkg;

  localparam logic [1:0] REG_COUNT  = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_CMP    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_ONESHOT   = 1;
  localparam int CTRL_IE_CMP    = 2;
  localparam int CTRL_IE_OVF    = 3;
  localparam int CTRL_CASCADE   = 4;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int PRESC_MAX_W    = 8;

  typedef struct packed {
    logic [PRESC_MAX_W-1:0] presc;
    logic                   cascade;
    logic                   ie_ovf;
    logic                   ie_cmp;
    logic                   oneshot;
    logic                   en;
  } ctrl_t;

  typedef struct packed {
    logic ovf;
    logic cmp;
  } status_t;

  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN]      = c.en;
    w[CTRL_ONESHOT] = c.oneshot;
    w[CTRL_IE_CMP]  = c.ie_cmp;
    w[CTRL_IE_OVF]  = c.ie_ovf;
    w[CTRL_CASCADE] = c.cascade;
    w[CTRL_PRESC_LSB +: PRESC_MAX_W] = c.presc;
    return w;
  endfunction

endpackage

// File: rtl/apb_timer_multi_channel.sv
// One timer channel: registers, prescaler, tick and match logic.
// TIMER_CASCADE_EN makes CTRL.CASCADE writable.
module timer_channel
  import apb_timer_multi_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int PRESC_WIDTH = 8,
  parameter bit HAS_PREV    = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr,
  input  logic [1:0]           i_reg,
  input  logic [31:0]          i_wdata,
  input  logic                 i_casc_evt,
  output logic [CNT_WIDTH-1:0] o_count,
  output ctrl_t                o_ctrl,
  output logic [CNT_WIDTH-1:0] o_cmp,
  output status_t              o_status,
  output logic                 o_irq,
  output logic                 o_cmp_evt
);

  localparam logic [PRESC_MAX_W-1:0] PRESC_MASK =
    PRESC_MAX_W'((16'd1 << PRESC_WIDTH) - 16'd1);
  localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;

  logic [CNT_WIDTH-1:0]   r_count;
  logic [CNT_WIDTH-1:0]   r_cmp;
  ctrl_t                  r_ctrl;
  status_t                r_status;
  logic [PRESC_MAX_W-1:0] r_pcnt;

  logic    w_wr_count;
  logic    w_wr_ctrl;
  logic    w_wr_cmp;
  logic    w_wr_status;
  logic    w_presc_tick;
  logic    w_casc_sel;
  logic    w_tick;
  logic    w_match;
  logic    w_ovf;
  logic [1:0] w_status_nxt;
  ctrl_t   w_ctrl_wr;
  logic    w_unused;

  assign w_wr_count  = i_wr && (i_reg == REG_COUNT);
  assign w_wr_ctrl   = i_wr && (i_reg == REG_CTRL);
  assign w_wr_cmp    = i_wr && (i_reg == REG_CMP);
  assign w_wr_status = i_wr && (i_reg == REG_STATUS);

  assign w_presc_tick = r_ctrl.en && (r_pcnt == r_ctrl.presc);
  assign w_casc_sel   = HAS_PREV && r_ctrl.cascade;
  assign w_tick = w_casc_sel ? (r_ctrl.en && i_casc_evt)
                             : w_presc_tick;

  // Compare branch is checked first so CMP == all-ones never flags OVF
  assign w_match = w_tick && (r_cmp != '0) && (r_count == r_cmp);
  assign w_ovf   = w_tick && !w_match && (r_count == ALL_ONES);

  always_comb begin
    w_ctrl_wr         = '0;
    w_ctrl_wr.en      = i_wdata[CTRL_EN];
    w_ctrl_wr.oneshot = i_wdata[CTRL_ONESHOT];
    w_ctrl_wr.ie_cmp  = i_wdata[CTRL_IE_CMP];
    w_ctrl_wr.ie_ovf  = i_wdata[CTRL_IE_OVF];
    w_ctrl_wr.presc   =
      i_wdata[CTRL_PRESC_LSB +: PRESC_MAX_W] & PRESC_MASK;
`ifdef TIMER_CASCADE_EN
    w_ctrl_wr.cascade = i_wdata[CTRL_CASCADE];
`else
    w_ctrl_wr.cascade = 1'b0;
`endif
  end

  // Hardware set beats a same-cycle W1C clear
  always_comb begin
    w_status_nxt = r_status;
    if (w_wr_status)
      w_status_nxt = w_status_nxt & ~i_wdata[1:0];
    w_status_nxt = w_status_nxt | {w_ovf, w_match};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count  <= '0;
      r_cmp    <= '0;
      r_ctrl   <= '0;
      r_status <= '0;
      r_pcnt   <= '0;
    end else begin
      if (w_wr_count || w_wr_cmp || !r_ctrl.en || w_presc_tick)
        r_pcnt <= '0;
      else
        r_pcnt <= r_pcnt + 8'd1;

      if (w_wr_count)
        r_count <= i_wdata[CNT_WIDTH-1:0];
      else if (w_wr_cmp || w_match || w_ovf)
        r_count <= '0;
      else if (w_tick)
        r_count <= r_count + CNT_WIDTH'(1);

      if (w_wr_cmp)
        r_cmp <= i_wdata[CNT_WIDTH-1:0];

      if (w_wr_ctrl)
        r_ctrl <= w_ctrl_wr;
      else if (w_match && r_ctrl.oneshot)
        r_ctrl.en <= 1'b0;

      r_status <= status_t'(w_status_nxt);
    end
  end

  assign o_count   = r_count;
  assign o_ctrl    = r_ctrl;
  assign o_cmp     = r_cmp;
  assign o_status  = r_status;
  assign o_cmp_evt = w_match;
  assign o_irq     = |(r_status & {r_ctrl.ie_ovf, r_ctrl.ie_cmp});

  assign w_unused = ^{i_wdata, i_casc_evt};

endmodule

// File: rtl/apb_timer_multi.sv
// Multi-channel APB timer: bus decode, read mux and channel array.
// Define TIMER_CASCADE_EN to chain channel i's tick to channel i-1 matches.
module apb_timer_multi
  import apb_timer_multi_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_TIMERS       = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int PRESC_WIDTH    = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [N_TIMERS-1:0]       irq_o
);

  logic [3:0]        w_ch;
  logic [1:0]        w_reg;
  logic              w_access;
  logic              w_valid_ch;
  logic              w_write;
  logic              w_read;
  logic [N_TIMERS:0] w_evt_chain;
  logic [31:0]       w_rd [N_TIMERS];
  logic              w_unused;

  assign w_ch       = PADDR[7:4];
  assign w_reg      = PADDR[3:2];
  assign w_access   = PSEL && PENABLE;
  assign w_valid_ch = int'(w_ch) < N_TIMERS;
  assign w_write    = w_access && PWRITE && w_valid_ch;
  assign w_read     = w_access && !PWRITE && w_valid_ch;

  assign PREADY  = 1'b1;
  assign PSLVERR = w_access && !w_valid_ch;

  // Channel 0 has no upstream match source
  assign w_evt_chain[0] = 1'b0;

  for (genvar g = 0; g < N_TIMERS; g++) begin : g_ch
    logic [CNT_WIDTH-1:0] w_count;
    logic [CNT_WIDTH-1:0] w_cmp;
    ctrl_t                w_ctrl;
    status_t              w_status;
    logic                 w_wr_ch;
    logic [31:0]          w_rd_ch;

    assign w_wr_ch = w_write && (w_ch == 4'(g));

    timer_channel #(
      .CNT_WIDTH   (CNT_WIDTH),
      .PRESC_WIDTH (PRESC_WIDTH),
      .HAS_PREV    (g > 0)
    ) u_ch (
      .i_clk      (HCLK),
      .i_rst      (HRESET),
      .i_wr       (w_wr_ch),
      .i_reg      (w_reg),
      .i_wdata    (PWDATA),
      .i_casc_evt (w_evt_chain[g]),
      .o_count    (w_count),
      .o_ctrl     (w_ctrl),
      .o_cmp      (w_cmp),
      .o_status   (w_status),
      .o_irq      (irq_o[g]),
      .o_cmp_evt  (w_evt_chain[g+1])
    );

    always_comb begin
      w_rd_ch = '0;
      unique case (1'b1)
        (w_reg == REG_COUNT):  w_rd_ch = 32'(w_count);
        (w_reg == REG_CTRL):   w_rd_ch = ctrl_to_word(w_ctrl);
        (w_reg == REG_CMP):    w_rd_ch = 32'(w_cmp);
        (w_reg == REG_STATUS): w_rd_ch = {30'd0, w_status};
      endcase
    end

    assign w_rd[g] = w_rd_ch;
  end

  always_comb begin
    PRDATA = '0;
    for (int i = 0; i < N_TIMERS; i++)
      if (w_read && (w_ch == 4'(i)))
        PRDATA = w_rd[i];
  end

  assign w_unused = ^{PADDR, w_evt_chain[N_TIMERS]};

endmodule

// File: tb/tb_apb_timer_multi.sv
// Directed bench for apb_timer_multi (4 channels, 8-bit counters).
// Build with TIMER_CASCADE_EN to exercise channel chaining.
module tb_apb_timer_multi;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [3:0]  irq_o;

  int   n_vec = 0;
  int   n_err = 0;
  logic wr_err;

  apb_timer_multi #(
    .APB_ADDR_WIDTH (12),
    .N_TIMERS       (4),
    .CNT_WIDTH      (8),
    .PRESC_WIDTH    (8)
  ) dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .irq_o   (irq_o)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
    PADDR = a; PWDATA = d; PWRITE = 1'b1;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1 wr_err = PSLVERR;
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [11:0] a,
                        output logic [31:0] d, output logic e);
    PADDR = a; PWRITE = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA; e = PSLVERR;
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    do_reset();
    n_vec++;
    if (irq_o !== 4'h0) begin
      n_err++; $display("FAIL rst_irq: got %h want 0", irq_o);
    end
    n_vec++;
    if ({PRDATA, PSLVERR, PREADY} !== {32'h0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL rst_bus: prdata %h slverr %b pready %b want 0 0 1",
               PRDATA, PSLVERR, PREADY);
    end
    apb_rd(12'h008, d, e);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL rst_cmp0: got %h want 0", d);
    end
    apb_rd(12'h03C, d, e);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL rst_status3: got %h want 0", d);
    end
  endtask

  task automatic test_compare_irq();
    logic [31:0] d; logic e;
    do_reset();
    apb_wr(12'h008, 32'd5);
    apb_wr(12'h004, 32'h5);
    wait_cyc(5);
    n_vec++;
    if (irq_o[0] !== 1'b0) begin
      n_err++; $display("FAIL cmp_irq_early: got %b want 0", irq_o[0]);
    end
    apb_rd(12'h000, d, e);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL cmp_count_wrap: got %h want 0", d);
    end
    n_vec++;
    if (irq_o[0] !== 1'b1) begin
      n_err++; $display("FAIL cmp_irq_set: got %b want 1", irq_o[0]);
    end
    apb_wr(12'h00C, 32'h1);
    n_vec++;
    if (irq_o[0] !== 1'b0) begin
      n_err++; $display("FAIL cmp_w1c: got %b want 0", irq_o[0]);
    end
  endtask

  task automatic test_oneshot_presc();
    logic [31:0] d; logic e;
    do_reset();
    apb_wr(12'h008, 32'd2);
    apb_wr(12'h004, 32'h303);
    wait_cyc(2);
    apb_rd(12'h000, d, e);
    n_vec++;
    if (d !== 32'd0) begin
      n_err++; $display("FAIL os_count_c3: got %h want 0", d);
    end
    apb_rd(12'h000, d, e);
    n_vec++;
    if (d !== 32'd1) begin
      n_err++; $display("FAIL os_count_c5: got %h want 1", d);
    end
    wait_cyc(1);
    apb_rd(12'h000, d, e);
    n_vec++;
    if (d !== 32'd2) begin
      n_err++; $display("FAIL os_count_c8: got %h want 2", d);
    end
    wait_cyc(2);
    apb_rd(12'h00C, d, e);
    n_vec++;
    if (d !== 32'h1) begin
      n_err++; $display("FAIL os_status: got %h want 1", d);
    end
    apb_rd(12'h004, d, e);
    n_vec++;
    if (d !== 32'h302) begin
      n_err++; $display("FAIL os_ctrl_en: got %h want 302", d);
    end
    apb_rd(12'h000, d, e);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL os_count_hold: got %h want 0", d);
    end
    n_vec++;
    if (irq_o[0] !== 1'b0) begin
      n_err++; $display("FAIL os_irq_masked: got %b want 0", irq_o[0]);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic e;
    do_reset();
    apb_wr(12'h000, 32'hFE);
    apb_wr(12'h004, 32'h9);
    apb_rd(12'h000, d, e);
    n_vec++;
    if (d !== 32'hFF) begin
      n_err++; $display("FAIL ovf_count_ff: got %h want ff", d);
    end
    n_vec++;
    if (irq_o[0] !== 1'b1) begin
      n_err++; $display("FAIL ovf_irq: got %b want 1", irq_o[0]);
    end
    apb_rd(12'h00C, d, e);
    n_vec++;
    if (d !== 32'h2) begin
      n_err++; $display("FAIL ovf_status: got %h want 2", d);
    end
    apb_rd(12'h000, d, e);
    n_vec++;
    if (d !== 32'h3) begin
      n_err++; $display("FAIL ovf_count_after: got %h want 3", d);
    end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d; logic e;
    do_reset();
    apb_wr(12'h008, 32'd3);
    apb_wr(12'h004, 32'h5);
    wait_cyc(6);
    n_vec++;
    if (irq_o[0] !== 1'b1) begin
      n_err++; $display("FAIL w1c_first_match: got %b want 1", irq_o[0]);
    end
    apb_wr(12'h00C, 32'h1);
    n_vec++;
    if (irq_o[0] !== 1'b1) begin
      n_err++; $display("FAIL w1c_collide: got %b want 1", irq_o[0]);
    end
    apb_wr(12'h00C, 32'h1);
    n_vec++;
    if (irq_o[0] !== 1'b0) begin
      n_err++; $display("FAIL w1c_clear: got %b want 0", irq_o[0]);
    end
    apb_rd(12'h00C, d, e);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL w1c_status: got %h want 0", d);
    end
  endtask

  task automatic test_bad_channel_reset();
    logic [31:0] d; logic e;
    do_reset();
    apb_wr(12'h000, 32'h12);
    apb_wr(12'h040, 32'h55);
    n_vec++;
    if (wr_err !== 1'b1) begin
      n_err++; $display("FAIL bad_wr_slverr: got %b want 1", wr_err);
    end
    apb_wr(12'h044, 32'h1);
    apb_rd(12'h040, d, e);
    n_vec++;
    if ({d, e} !== {32'h0, 1'b1}) begin
      n_err++; $display("FAIL bad_rd: got %h/%b want 0/1", d, e);
    end
    apb_rd(12'h000, d, e);
    n_vec++;
    if ({d, e} !== {32'h12, 1'b0}) begin
      n_err++; $display("FAIL bad_ch0_intact: got %h/%b want 12/0", d, e);
    end
    apb_rd(12'h004, d, e);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL bad_ctrl_intact: got %h want 0", d);
    end
    apb_wr(12'h014, 32'h1);
    wait_cyc(3);
    do_reset();
    apb_rd(12'h010, d, e);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL mid_rst_count1: got %h want 0", d);
    end
    apb_rd(12'h014, d, e);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL mid_rst_ctrl1: got %h want 0", d);
    end
    apb_rd(12'h000, d, e);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL mid_rst_count0: got %h want 0", d);
    end
  endtask

  task automatic test_cascade();
    logic [31:0] d; logic e;
    do_reset();
`ifdef TIMER_CASCADE_EN
    apb_wr(12'h018, 32'd2);
    apb_wr(12'h014, 32'h15);
    apb_wr(12'h008, 32'd3);
    apb_wr(12'h004, 32'h1);
    wait_cyc(11);
    n_vec++;
    if (irq_o[1] !== 1'b0) begin
      n_err++; $display("FAIL casc_early: got %b want 0", irq_o[1]);
    end
    wait_cyc(1);
    n_vec++;
    if (irq_o[1] !== 1'b1) begin
      n_err++; $display("FAIL casc_irq: got %b want 1", irq_o[1]);
    end
    apb_rd(12'h01C, d, e);
    n_vec++;
    if (d !== 32'h1) begin
      n_err++; $display("FAIL casc_status: got %h want 1", d);
    end
`else
    apb_wr(12'h014, 32'h10);
    apb_rd(12'h014, d, e);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL casc_disabled: got %h want 0", d);
    end
`endif
  endtask

  initial begin
    HRESET = 1'b1; PADDR = '0; PWDATA = '0;
    PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    wr_err = 1'b0;
    wait_cyc(3);
    HRESET = 1'b0;
    test_reset();
    test_compare_irq();
    test_oneshot_presc();
    test_overflow();
    test_w1c_collision();
    test_bad_channel_reset();
    test_cascade();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
